// File: rtl/bus_responder.sv
// bus_responder: memory-side responder serving fetch/load/store requests from the control unit.
// Ports:
//   CLK, RST_N                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake; req_type 00 fetch, 01 load, 10 store, 11 reserved
//   req_addr, req_wdata         PC (fetch) or RAM address (load/store), store data
//   rsp_valid/rsp_ready         response handshake; rsp_data result, rsp_err for reserved type
//   rom_addr, rom_data          synchronous ROM port (data one cycle after address)
//   ram_addr, ram_we, ram_wdata, ram_rdata   synchronous single-port RAM
// Optional feature: define BUS_RESPONDER_FETCH_CACHE_EN for a one-entry control-word cache.
module bus_responder #(
    parameter int ROM_AW = 16,
    parameter int RAM_AW = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [15:0]       req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata
);
    typedef enum logic [2:0] {IDLE, F_LO, F_HI, F_CAP, L_RD, L_CAP, ST, RESP} state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_we_q, ram_we_d;
    logic [15:0]         ram_wdata_q, ram_wdata_d;
    logic [15:0]         lo_q, lo_d;
`ifdef BUS_RESPONDER_FETCH_CACHE_EN
    logic                cache_valid_q, cache_valid_d;
    logic [15:0]         cache_tag_q, cache_tag_d;
    logic [31:0]         cache_word_q, cache_word_d;
    logic [15:0]         addr_q, addr_d;
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rom_addr  = rom_addr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

    always_comb begin
        state_d     = state_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rom_addr_d  = rom_addr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        lo_d        = lo_q;
        ram_we_d    = 1'b0;
`ifdef BUS_RESPONDER_FETCH_CACHE_EN
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_word_d  = cache_word_q;
        addr_d        = addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
`ifdef BUS_RESPONDER_FETCH_CACHE_EN
                    addr_d = req_addr;
`endif
                    case (req_type)
                        2'b00: begin
`ifdef BUS_RESPONDER_FETCH_CACHE_EN
                            if (cache_valid_q && cache_tag_q == req_addr) begin
                                state_d    = RESP;
                                rsp_data_d = cache_word_q;
                                rsp_err_d  = 1'b0;
                            end else begin
                                state_d    = F_LO;
                                rom_addr_d = ROM_AW'({req_addr, 1'b0});
                            end
`else
                            state_d    = F_LO;
                            rom_addr_d = ROM_AW'({req_addr, 1'b0});
`endif
                        end
                        2'b01: begin
                            state_d    = L_RD;
                            ram_addr_d = req_addr[RAM_AW-1:0];
                        end
                        2'b10: begin
                            // Address, data and strobe all launch from this edge so they are valid together in ST.
                            state_d     = ST;
                            ram_addr_d  = req_addr[RAM_AW-1:0];
                            ram_wdata_d = req_wdata;
                            ram_we_d    = 1'b1;
                            rsp_data_d  = 32'h0;
                            rsp_err_d   = 1'b0;
                        end
                        default: begin
                            state_d    = RESP;
                            rsp_data_d = 32'h0;
                            rsp_err_d  = 1'b1;
                        end
                    endcase
                end
            end
            // Second ROM word address wraps naturally at the ROM_AW width.
            F_LO:  begin
                state_d    = F_HI;
                rom_addr_d = rom_addr_q + ROM_AW'(1);
            end
            F_HI:  begin
                state_d = F_CAP;
                lo_d    = rom_data;
            end
            F_CAP: begin
                state_d    = RESP;
                rsp_data_d = {rom_data, lo_q};
                rsp_err_d  = 1'b0;
`ifdef BUS_RESPONDER_FETCH_CACHE_EN
                cache_valid_d = 1'b1;
                cache_tag_d   = addr_q;
                cache_word_d  = {rom_data, lo_q};
`endif
            end
            L_RD:  state_d = L_CAP;
            L_CAP: begin
                state_d    = RESP;
                rsp_data_d = {16'h0, ram_rdata};
                rsp_err_d  = 1'b0;
            end
            ST:    state_d = RESP;
            RESP:  state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= 16'h0;
            lo_q        <= 16'h0;
`ifdef BUS_RESPONDER_FETCH_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_tag_q   <= 16'h0;
            cache_word_q  <= 32'h0;
            addr_q        <= 16'h0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            lo_q        <= lo_d;
`ifdef BUS_RESPONDER_FETCH_CACHE_EN
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_word_q  <= cache_word_d;
            addr_q        <= addr_d;
`endif
        end
    end
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: randomized self-checking bench for bus_responder against a request-level model.
// Ports: none; drives the DUT with sync ROM/RAM models and compares each response to the model.
module tb_bus_responder;
    logic        CLK = 1'b0, RST_N = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [1:0]  req_type = 2'b00;
    logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
    logic        rsp_valid, rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] rom_addr, rom_data, ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;

`ifdef BUS_RESPONDER_FETCH_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic [15:0] rom [0:65535];
    logic [15:0] ram_mem [0:65535];
    logic [15:0] ref_ram [0:65535];
    bit          cache_v;
    logic [15:0] cache_a;

    int tests_run = 0, tests_failed = 0;
    int r_lat, r_wait, r_we_n, r_we_cyc, r_rom_moved, r_busy_rdy, r_unstable;
    logic [15:0] r_we_a, r_we_d, r_rom0, r_rom1;
    logic [31:0] r_d;
    logic        r_e, r_rdy_after;

    bus_responder dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        rom_data <= rom[rom_addr];
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] fetch_word(input logic [15:0] a);
        int lo;
        lo = (2 * int'(a)) % 65536;
        return {rom[(lo + 1) % 65536], rom[lo]};
    endfunction

    function automatic int exp_lat(input logic [1:0] t, input logic [15:0] a);
        if (t == 2'b00) return (CACHE && cache_v && cache_a == a) ? 1 : 4;
        return (t == 2'b01) ? 3 : (t == 2'b10) ? 2 : 1;
    endfunction

    function automatic logic [31:0] exp_data(input logic [1:0] t, input logic [15:0] a);
        if (t == 2'b00) return fetch_word(a);
        if (t == 2'b01) return {16'h0, ref_ram[a]};
        return 32'h0;
    endfunction

    task automatic model_update(input logic [1:0] t, input logic [15:0] a, input logic [15:0] wd);
        if (t == 2'b10) ref_ram[a] = wd;
        if (t == 2'b00) begin
            cache_v = 1'b1;
            cache_a = a;
        end
    endtask

    // Runs one request from the next free accept slot through its response handshake,
    // recording what was observed in the r_* variables. hold = cycles rsp_ready stays low
    // after rsp_valid; keep = leave req_valid high carrying the next request meanwhile.
    task automatic issue(input logic [1:0] t, input logic [15:0] a, input logic [15:0] wd,
                         input int hold, input bit keep, input logic [1:0] nt, input logic [15:0] na);
        logic [15:0] rom_start;
        r_wait = 0; r_we_n = 0; r_we_cyc = 0; r_rom_moved = 0; r_busy_rdy = 0; r_unstable = 0;
        r_we_a = 16'h0; r_we_d = 16'h0; r_d = 32'h0; r_e = 1'b0; r_rdy_after = 1'b0;
        while (!req_ready && r_wait < 50) begin
            @(negedge CLK);
            r_wait++;
        end
        if (!req_ready) begin
            r_lat = -1;
            return;
        end
        rom_start = rom_addr;
        r_rom0 = rom_addr;
        r_rom1 = rom_addr;
        req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = wd;
        rsp_ready = (hold == 0);
        @(posedge CLK);
        @(negedge CLK);
        if (keep) begin
            req_type = nt;
            req_addr = na;
        end else req_valid = 1'b0;
        for (r_lat = 1; r_lat <= 20; r_lat++) begin
            if (ram_we) begin
                r_we_n++; r_we_cyc = r_lat; r_we_a = ram_addr; r_we_d = ram_wdata;
            end
            if (rom_addr != rom_start) r_rom_moved++;
            if (r_lat == 1) r_rom0 = rom_addr;
            if (r_lat == 2) r_rom1 = rom_addr;
            if (rsp_valid) break;
            if (req_ready) r_busy_rdy++;
            @(negedge CLK);
        end
        if (!rsp_valid) begin
            r_lat = -1;
            rsp_ready = 1'b1;
            return;
        end
        r_d = rsp_data;
        r_e = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            if (!rsp_valid || rsp_data !== r_d || rsp_err !== r_e) r_unstable++;
            if (req_ready) r_busy_rdy++;
            if (ram_we) r_we_n++;
        end
        rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        r_rdy_after = req_ready;
    endtask

    task automatic test_reset;
        RST_N = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        cache_v = 1'b0;
        @(negedge CLK);
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        tests_run++; if (rsp_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        tests_run++; if (rom_addr !== 16'h0) begin tests_failed++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
        tests_run++; if (ram_addr !== 16'h0) begin tests_failed++; $display("FAIL reset_ram_addr got %h exp 0", ram_addr); end
        tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
        tests_run++; if (ram_wdata !== 16'h0) begin tests_failed++; $display("FAIL reset_ram_wdata got %h exp 0", ram_wdata); end
    endtask

    task automatic test_fetch;
        issue(2'b00, 16'h0003, 16'h0, 0, 1'b0, 2'b00, 16'h0);
        model_update(2'b00, 16'h0003, 16'h0);
        tests_run++; if (r_lat !== 4) begin tests_failed++; $display("FAIL fetch_latency got %0d exp 4", r_lat); end
        tests_run++; if (r_d !== 32'hABCD1234) begin tests_failed++; $display("FAIL fetch_data got %h exp ABCD1234", r_d); end
        tests_run++; if (r_e !== 1'b0) begin tests_failed++; $display("FAIL fetch_err got %b exp 0", r_e); end
        tests_run++; if (r_rom0 !== 16'h0006) begin tests_failed++; $display("FAIL fetch_rom_lo got %h exp 0006", r_rom0); end
        tests_run++; if (r_rom1 !== 16'h0007) begin tests_failed++; $display("FAIL fetch_rom_hi got %h exp 0007", r_rom1); end
    endtask

    task automatic test_cache;
        int el;
        el = exp_lat(2'b00, 16'h0003);
        issue(2'b00, 16'h0003, 16'h0, 0, 1'b0, 2'b00, 16'h0);
        model_update(2'b00, 16'h0003, 16'h0);
        tests_run++; if (r_lat !== el) begin tests_failed++; $display("FAIL refetch_latency got %0d exp %0d", r_lat, el); end
        tests_run++; if (r_d !== 32'hABCD1234) begin tests_failed++; $display("FAIL refetch_data got %h exp ABCD1234", r_d); end
        tests_run++; if ((r_rom_moved == 0) !== CACHE) begin tests_failed++; $display("FAIL refetch_rom_untouched got %0d moves exp_cache %b", r_rom_moved, CACHE); end
    endtask

    task automatic test_store_load;
        issue(2'b10, 16'h0040, 16'h5A5A, 0, 1'b0, 2'b00, 16'h0);
        model_update(2'b10, 16'h0040, 16'h5A5A);
        tests_run++; if (r_lat !== 2) begin tests_failed++; $display("FAIL store_latency got %0d exp 2", r_lat); end
        tests_run++; if (r_we_n !== 1) begin tests_failed++; $display("FAIL store_we_cycles got %0d exp 1", r_we_n); end
        tests_run++; if (r_we_cyc !== 1) begin tests_failed++; $display("FAIL store_we_cycle got %0d exp 1", r_we_cyc); end
        tests_run++; if (r_we_a !== 16'h0040) begin tests_failed++; $display("FAIL store_addr got %h exp 0040", r_we_a); end
        tests_run++; if (r_we_d !== 16'h5A5A) begin tests_failed++; $display("FAIL store_wdata got %h exp 5A5A", r_we_d); end
        tests_run++; if (r_d !== 32'h0) begin tests_failed++; $display("FAIL store_rsp_data got %h exp 0", r_d); end
        issue(2'b01, 16'h0040, 16'h0, 0, 1'b0, 2'b00, 16'h0);
        tests_run++; if (r_lat !== 3) begin tests_failed++; $display("FAIL load_latency got %0d exp 3", r_lat); end
        tests_run++; if (r_d !== 32'h00005A5A) begin tests_failed++; $display("FAIL load_data got %h exp 00005A5A", r_d); end
    endtask

    task automatic test_back_to_back;
        int el;
        issue(2'b01, 16'h0040, 16'h0, 6, 1'b1, 2'b00, 16'h0003);
        tests_run++; if (r_unstable !== 0) begin tests_failed++; $display("FAIL stall_stable got %0d changes exp 0", r_unstable); end
        tests_run++; if (r_busy_rdy !== 0) begin tests_failed++; $display("FAIL stall_req_ready got %0d high cycles exp 0", r_busy_rdy); end
        tests_run++; if (r_d !== 32'h00005A5A) begin tests_failed++; $display("FAIL stall_data got %h exp 00005A5A", r_d); end
        tests_run++; if (r_rdy_after !== 1'b1) begin tests_failed++; $display("FAIL stall_ready_after got %b exp 1", r_rdy_after); end
        el = exp_lat(2'b00, 16'h0003);
        issue(2'b00, 16'h0003, 16'h0, 0, 1'b0, 2'b00, 16'h0);
        model_update(2'b00, 16'h0003, 16'h0);
        tests_run++; if (r_wait !== 0) begin tests_failed++; $display("FAIL held_req_wait got %0d exp 0", r_wait); end
        tests_run++; if (r_lat !== el) begin tests_failed++; $display("FAIL held_req_latency got %0d exp %0d", r_lat, el); end
        tests_run++; if (r_d !== 32'hABCD1234) begin tests_failed++; $display("FAIL held_req_data got %h exp ABCD1234", r_d); end
    endtask

    task automatic test_wrap;
        issue(2'b00, 16'hFFFF, 16'h0, 0, 1'b0, 2'b00, 16'h0);
        model_update(2'b00, 16'hFFFF, 16'h0);
        tests_run++; if (r_rom0 !== 16'hFFFE) begin tests_failed++; $display("FAIL wrap_top_lo got %h exp FFFE", r_rom0); end
        tests_run++; if (r_rom1 !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_top_hi got %h exp FFFF", r_rom1); end
        tests_run++; if (r_d !== fetch_word(16'hFFFF)) begin tests_failed++; $display("FAIL wrap_top_data got %h exp %h", r_d, fetch_word(16'hFFFF)); end
        issue(2'b00, 16'h8000, 16'h0, 0, 1'b0, 2'b00, 16'h0);
        model_update(2'b00, 16'h8000, 16'h0);
        tests_run++; if (r_rom0 !== 16'h0000) begin tests_failed++; $display("FAIL wrap_lo got %h exp 0000", r_rom0); end
        tests_run++; if (r_rom1 !== 16'h0001) begin tests_failed++; $display("FAIL wrap_hi got %h exp 0001", r_rom1); end
        tests_run++; if (r_d !== fetch_word(16'h8000)) begin tests_failed++; $display("FAIL wrap_data got %h exp %h", r_d, fetch_word(16'h8000)); end
    endtask

    task automatic test_reserved;
        issue(2'b11, 16'h1234, 16'hBEEF, 0, 1'b0, 2'b00, 16'h0);
        tests_run++; if (r_lat !== 1) begin tests_failed++; $display("FAIL rsvd_latency got %0d exp 1", r_lat); end
        tests_run++; if (r_e !== 1'b1) begin tests_failed++; $display("FAIL rsvd_err got %b exp 1", r_e); end
        tests_run++; if (r_d !== 32'h0) begin tests_failed++; $display("FAIL rsvd_data got %h exp 0", r_d); end
        tests_run++; if (r_we_n !== 0) begin tests_failed++; $display("FAIL rsvd_we got %0d exp 0", r_we_n); end
        tests_run++; if (r_rom_moved !== 0) begin tests_failed++; $display("FAIL rsvd_rom got %0d moves exp 0", r_rom_moved); end
    endtask

    task automatic test_reset_in_store;
        int seen;
        seen = 0;
        req_valid = 1'b1; req_type = 2'b10; req_addr = 16'h0055; req_wdata = 16'h7777;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        tests_run++; if (ram_we !== 1'b1) begin tests_failed++; $display("FAIL rst_st_we_before got %b exp 1", ram_we); end
        RST_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        // The strobe was still presented on the reset edge, so the RAM took the write.
        ref_ram[16'h0055] = 16'h7777;
        cache_v = 1'b0;
        tests_run++; if (ram_we !== 1'b0) begin tests_failed++; $display("FAIL rst_st_we_after got %b exp 0", ram_we); end
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen++;
            @(negedge CLK);
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL rst_st_rsp_valid got %0d cycles exp 0", seen); end
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_st_req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_random;
        logic [1:0]  t;
        logic [15:0] a, wd;
        int el;
        logic [31:0] ed;
        for (int n = 0; n < 40; n++) begin
            t  = 2'($urandom_range(0, 3));
            a  = 16'($urandom_range(0, 15));
            wd = 16'($urandom);
            el = exp_lat(t, a);
            ed = exp_data(t, a);
            issue(t, a, wd, $urandom_range(0, 2), 1'b0, 2'b00, 16'h0);
            model_update(t, a, wd);
            tests_run++; if (r_lat !== el) begin tests_failed++; $display("FAIL rand_latency n=%0d type=%0d addr=%h got %0d exp %0d", n, t, a, r_lat, el); end
            tests_run++; if (r_d !== ed) begin tests_failed++; $display("FAIL rand_data n=%0d type=%0d addr=%h got %h exp %h", n, t, a, r_d, ed); end
            tests_run++; if (r_e !== (t == 2'b11)) begin tests_failed++; $display("FAIL rand_err n=%0d type=%0d got %b exp %b", n, t, r_e, t == 2'b11); end
            tests_run++; if (r_we_n !== int'(t == 2'b10)) begin tests_failed++; $display("FAIL rand_we n=%0d type=%0d got %0d exp %0d", n, t, r_we_n, int'(t == 2'b10)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            rom[i] = 16'($urandom);
            ram_mem[i] = 16'($urandom);
            ref_ram[i] = ram_mem[i];
        end
        rom[6] = 16'h1234;
        rom[7] = 16'hABCD;
        cache_v = 1'b0;
        cache_a = 16'h0;
        test_reset;
        test_fetch;
        test_cache;
        test_store_load;
        test_back_to_back;
        test_wrap;
        test_reserved;
        test_reset_in_store;
        test_store_load;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
